// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, state numbers,
// datapath select codes and the internal control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11
  } state_e;

  localparam logic [2:0] ALUOP_ADD   = 3'b100;
  localparam logic [2:0] ALUOP_OR    = 3'b101;
  localparam logic [2:0] ALUOP_SUB   = 3'b011;
  localparam logic [2:0] ALUOP_FUNCT = 3'b111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       memto_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       branch_eq;
    logic       branch_ne;
    logic       illegal;
  } ctrl_word_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath signal bundle; master is the controller side.
interface multicycle_control_if;
  logic [5:0] OP;
  logic       Zero;
  logic       MemReady;
  logic       PCEn;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic       BranchEQ;
  logic       BranchNE;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    input  OP, Zero, MemReady,
    output PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, BranchEQ, BranchNE, Illegal, State
  );

  modport slave (
    output OP, Zero, MemReady,
    input  PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, BranchEQ, BranchNE, Illegal, State
  );
endinterface

// File: rtl/multicycle_control_output_decode.sv
// Combinational map from (state, opcode, memory ready) to the control word.
module control_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output ctrl_word_t cw
);

  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.mem_read  = 1'b1;
        cw.alu_src_b = SRCB_FOUR;
        cw.alu_op    = ALUOP_ADD;
        cw.ir_write  = mem_ready;
        cw.pc_write  = mem_ready;
      end
      S_DECODE: begin
        cw.alu_src_b = SRCB_IMM_SH;
        cw.alu_op    = ALUOP_ADD;
        case (op)
          OP_RTYPE, OP_J, OP_BEQ, OP_BNE,
          OP_ADDI, OP_ORI, OP_LW, OP_SW: cw.illegal = 1'b0;
          default:                       cw.illegal = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        cw.mem_read = 1'b1;
        cw.iord     = 1'b1;
      end
      S_MEM_WB: begin
        cw.reg_write = 1'b1;
        cw.memto_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        cw.mem_write = 1'b1;
        cw.iord      = 1'b1;
      end
      S_EXECUTE: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_REG;
        cw.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        cw.reg_write = 1'b1;
        cw.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_REG;
        cw.alu_op    = ALUOP_SUB;
        cw.pc_source = PCSRC_ALUOUT;
        cw.branch_eq = (op == OP_BEQ);
        cw.branch_ne = (op == OP_BNE);
      end
      S_JUMP: begin
        cw.pc_source = PCSRC_JUMP;
        cw.pc_write  = 1'b1;
      end
      S_I_EXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = (op == OP_ADDI) ? ALUOP_ADD : ALUOP_OR;
      end
      S_I_WB: begin
        cw.reg_write = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencing controller: state register, next-state logic,
// reset gating of write strobes and PC enable.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  multicycle_control_if.master bus
);

  state_e     state_q, state_d;
  ctrl_word_t cw;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = bus.MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.OP)
          OP_RTYPE:        state_d = S_EXECUTE;
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_ADDI, OP_ORI: state_d = S_I_EXEC;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          default:         state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = (bus.OP == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = bus.MemReady ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: state_d = bus.MemReady ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_I_EXEC:    state_d = S_I_WB;
      S_I_WB:      state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  control_output_decode u_decode (
    .state     (state_q),
    .op        (bus.OP),
    .mem_ready (bus.MemReady),
    .cw        (cw)
  );

  // Write strobes are gated by reset directly so nothing commits while reset is low,
  // even though FETCH decodes IRWrite/PCWrite from MemReady.
  assign bus.PCEn     = (cw.pc_write | (cw.branch_eq & bus.Zero) | (cw.branch_ne & ~bus.Zero)) & reset;
  assign bus.IRWrite  = cw.ir_write & reset;
  assign bus.RegWrite = cw.reg_write & reset;
  assign bus.MemWrite = cw.mem_write & reset;
  assign bus.IorD     = cw.iord;
  assign bus.MemRead  = cw.mem_read;
  assign bus.RegDst   = cw.reg_dst;
  assign bus.MemtoReg = cw.memto_reg;
  assign bus.ALUSrcA  = cw.alu_src_a;
  assign bus.ALUSrcB  = cw.alu_src_b;
  assign bus.ALUOp    = cw.alu_op;
  assign bus.PCSource = cw.pc_source;
  assign bus.BranchEQ = cw.branch_eq;
  assign bus.BranchNE = cw.branch_ne;
  assign bus.Illegal  = cw.illegal;
  assign bus.State    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control against an instruction-level phase model.
module tb_multicycle_control;

  typedef int phase_q_t[$];

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_known(input logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h23, 6'h2B};
  endfunction

  // Sequence of state numbers each instruction walks through.
  function automatic phase_q_t phases(input logic [5:0] op);
    case (op)
      6'h00:        return '{0, 1, 6, 7};
      6'h23:        return '{0, 1, 2, 3, 4};
      6'h2B:        return '{0, 1, 2, 5};
      6'h08, 6'h0D: return '{0, 1, 10, 11};
      6'h04, 6'h05: return '{0, 1, 8};
      6'h02:        return '{0, 1, 9};
      default:      return '{0, 1};
    endcase
  endfunction

  function automatic bit is_wait(input int ph);
    return (ph == 0) || (ph == 3) || (ph == 5);
  endfunction

  // Expected control word: {PCEn,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,
  // RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,BranchEQ,BranchNE,Illegal}
  function automatic logic [18:0] exp_ctrl(input int ph, input logic [5:0] op,
                                           input logic mr, input logic z, input logic rst);
    logic pcw, pcen, iord, mrd, mwr, irw, rdst, m2r, rw, srca, beq, bne, ill;
    logic [1:0] srcb, pcs;
    logic [2:0] aop;
    {pcw, iord, mrd, mwr, irw, rdst, m2r, rw, srca, beq, bne, ill} = '0;
    srcb = 2'd0; pcs = 2'd0; aop = 3'd0;
    case (ph)
      0:  begin mrd = 1; srcb = 2'b01; aop = 3'b100; irw = mr; pcw = mr; end
      1:  begin srcb = 2'b11; aop = 3'b100; ill = !is_known(op); end
      2:  begin srca = 1; srcb = 2'b10; aop = 3'b100; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin srca = 1; aop = 3'b111; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin srca = 1; aop = 3'b011; pcs = 2'b01; beq = (op == 6'h04); bne = (op == 6'h05); end
      9:  begin pcs = 2'b10; pcw = 1; end
      10: begin srca = 1; srcb = 2'b10; aop = (op == 6'h08) ? 3'b100 : 3'b101; end
      11: begin rw = 1; end
      default: ;
    endcase
    pcen = pcw | (beq & z) | (bne & ~z);
    if (!rst) begin pcen = 0; irw = 0; rw = 0; mwr = 0; end
    return {pcen, iord, mrd, mwr, irw, rdst, m2r, rw, srca, srcb, aop, pcs, beq, bne, ill};
  endfunction

  task automatic step(input int ph, input logic [5:0] op, input logic mr,
                      input logic z, input logic rst);
    logic [18:0] got;
    @(negedge clk);
    bus.OP = op; bus.MemReady = mr; bus.Zero = z; reset = rst;
    #1;
    got = {bus.PCEn, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst,
           bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
           bus.PCSource, bus.BranchEQ, bus.BranchNE, bus.Illegal};
    check_eq("state", 32'(bus.State), 32'(ph));
    check_eq("ctrl", 32'(got), 32'(exp_ctrl(ph, op, mr, z, rst)));
  endtask

  // rnd=1: MemReady random every cycle; rnd=0: forced stall counts in FETCH and memory phases.
  task automatic run_instr(input logic [5:0] op, input int fetch_stall, input int mem_stall,
                           input int zmode, input bit rnd);
    phase_q_t ph;
    int idx, fs, ms;
    logic mr, z;
    ph = phases(op);
    idx = 0; fs = fetch_stall; ms = mem_stall;
    while (idx < ph.size()) begin
      if (rnd) mr = ($urandom_range(0, 3) != 0);
      else if (ph[idx] == 0) begin mr = (fs == 0); if (fs > 0) fs--; end
      else if (ph[idx] == 3 || ph[idx] == 5) begin mr = (ms == 0); if (ms > 0) ms--; end
      else mr = 1'($urandom_range(0, 1));
      z = (zmode < 0) ? 1'($urandom_range(0, 1)) : zmode[0];
      step(ph[idx], op, mr, z, 1'b1);
      if (!(is_wait(ph[idx]) && !mr)) idx++;
    end
  endtask

  initial begin
    logic [5:0] ops [8];
    logic [5:0] op;
    n_vec = 0; n_err = 0;
    ops = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h23, 6'h2B};
    reset = 1'b0; bus.OP = '0; bus.Zero = 1'b0; bus.MemReady = 1'b0;

    // Reset state, including MemReady high to expose strobe gating.
    step(0, 6'h00, 1'b0, 1'b0, 1'b0);
    step(0, 6'h00, 1'b1, 1'b1, 1'b0);

    run_instr(6'h00, 0, 0, -1, 1'b0);          // R-type add
    run_instr(6'h23, 0, 2, -1, 1'b0);          // LW with 2 stall cycles in MEM_READ
    run_instr(6'h04, 0, 0, 1, 1'b0);           // BEQ taken
    run_instr(6'h04, 0, 0, 0, 1'b0);           // BEQ not taken
    run_instr(6'h05, 0, 0, 1, 1'b0);           // BNE with Zero=1
    run_instr(6'h05, 0, 0, 0, 1'b0);           // BNE with Zero=0
    run_instr(6'h3F, 0, 0, -1, 1'b0);          // unknown opcode
    run_instr(6'h0D, 1, 0, -1, 1'b0);          // ORI with a fetch stall
    run_instr(6'h02, 0, 0, -1, 1'b0);          // J
    run_instr(6'h2B, 0, 3, -1, 1'b0);          // SW with stalls

    // Reset during a stalled MEM_WRITE aborts the store immediately.
    step(0, 6'h2B, 1'b1, 1'b0, 1'b1);
    step(1, 6'h2B, 1'b1, 1'b0, 1'b1);
    step(2, 6'h2B, 1'b1, 1'b0, 1'b1);
    step(5, 6'h2B, 1'b0, 1'b0, 1'b1);
    step(0, 6'h2B, 1'b1, 1'b0, 1'b0);
    step(0, 6'h2B, 1'b0, 1'b0, 1'b0);
    run_instr(6'h00, 0, 0, -1, 1'b0);          // fetch resumes right after release

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = 6'($urandom); while (is_known(op));
      end else begin
        op = ops[$urandom_range(0, 7)];
      end
      run_instr(op, 0, 0, -1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
